// File: rtl/fmap_writer_pkg.sv
// Shared defaults, word geometry and FSM state type for the feature-map writer.
// Build option: FMAP_WRITER_ZERO_PAD_EN selects zero padding of a short final word.
package fmap_pkg;

   localparam int WIDTH_DEF      = 57;
   localparam int HEIGHT_DEF     = 8;
   localparam int WIDTH_B_DEF    = 6;
   localparam int HEIGHT_B_DEF   = 3;
   localparam int BYTES_PER_WORD = 9;
   localparam int WORD_W         = 72;

   typedef enum logic {
      FILL  = 1'b0,
      WRITE = 1'b1
   } state_t;

endpackage

// File: rtl/fmap_writer_byte_packer.sv
// Collects accepted bytes into a 9-slot word; slots past the current count read as zero.
// FMAP_WRITER_ZERO_PAD_EN: in_last on a short word completes it (zero padded) instead of dropping it.
module byte_packer
   import fmap_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_accept,
   input  logic [7:0]        i_byte,
   input  logic              i_last,
   output logic              o_word_full,
   output logic              o_drop,
   output logic [WORD_W-1:0] o_word
);

   logic [7:0] r_slot [BYTES_PER_WORD];
   logic [3:0] r_byte_cnt;
   logic       w_last_slot;
   logic       w_pad;

   assign w_last_slot = (r_byte_cnt == 4'(BYTES_PER_WORD - 1));

`ifdef FMAP_WRITER_ZERO_PAD_EN
   assign w_pad  = i_last;
   assign o_drop = 1'b0;
`else
   assign w_pad  = 1'b0;
   assign o_drop = i_accept & i_last & ~w_last_slot;
`endif

   assign o_word_full = i_accept & (w_last_slot | w_pad);

   // The incoming byte is merged in directly so the word is complete on the accepting edge.
   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_slot
         assign o_word[WORD_W-1-8*gi -: 8] =
            (4'(gi) < r_byte_cnt)  ? r_slot[gi] :
            (4'(gi) == r_byte_cnt) ? i_byte     : 8'h00;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_byte_cnt <= '0;
      end else if (o_word_full | o_drop) begin
         r_byte_cnt <= '0;
      end else if (i_accept) begin
         r_slot[r_byte_cnt] <= i_byte;
         r_byte_cnt         <= r_byte_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/fmap_writer.sv
// Packs a byte stream into 72-bit words and writes them in raster order to the feature-map memory.
// FMAP_WRITER_ZERO_PAD_EN (in byte_packer) chooses padding versus dropping of a short final word.
module fmap_writer
   import fmap_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int HEIGHT   = HEIGHT_DEF,
   parameter int WIDTH_B  = WIDTH_B_DEF,
   parameter int HEIGHT_B = HEIGHT_B_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                in_valid,
   input  logic [7:0]          in_data,
   input  logic                in_last,
   output logic                in_ready,
   output logic                write_en,
   output logic [WIDTH_B-1:0]  write_w,
   output logic [HEIGHT_B-1:0] write_h,
   output logic [WORD_W-1:0]   write,
   output logic                frame_done,
   output logic                drop_err
);

   state_t              r_state;
   logic [WIDTH_B-1:0]  r_w_ptr;
   logic [HEIGHT_B-1:0] r_h_ptr;
   logic                r_write_en;
   logic [WIDTH_B-1:0]  r_write_w;
   logic [HEIGHT_B-1:0] r_write_h;
   logic [WORD_W-1:0]   r_write;
   logic                r_frame_done;
   logic                r_drop_err;

   logic                w_accept;
   logic                w_word_full;
   logic                w_drop;
   logic                w_last_col;
   logic                w_frame_end;
   logic [WORD_W-1:0]   w_word;

   assign in_ready    = en & ~reset & (r_state == FILL);
   assign w_accept    = in_valid & in_ready;
   assign w_last_col  = (r_w_ptr == WIDTH_B'(WIDTH - 1));
   assign w_frame_end = in_last | (w_last_col & (r_h_ptr == HEIGHT_B'(HEIGHT - 1)));

   byte_packer u_packer (
      .clk         (clk),
      .reset       (reset),
      .i_accept    (w_accept),
      .i_byte      (in_data),
      .i_last      (in_last),
      .o_word_full (w_word_full),
      .o_drop      (w_drop),
      .o_word      (w_word)
   );

   // A drop also takes the one-cycle WRITE bubble so no pulse output can repeat back to back.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= FILL;
         r_w_ptr      <= '0;
         r_h_ptr      <= '0;
         r_write_en   <= 1'b0;
         r_write_w    <= '0;
         r_write_h    <= '0;
         r_write      <= '0;
         r_frame_done <= 1'b0;
         r_drop_err   <= 1'b0;
      end else begin
         r_write_en   <= 1'b0;
         r_frame_done <= 1'b0;
         r_drop_err   <= 1'b0;
         case (r_state)
            FILL: begin
               if (w_word_full) begin
                  r_write      <= w_word;
                  r_write_w    <= r_w_ptr;
                  r_write_h    <= r_h_ptr;
                  r_write_en   <= 1'b1;
                  r_frame_done <= w_frame_end;
                  r_state      <= WRITE;
                  if (w_frame_end) begin
                     r_w_ptr <= '0;
                     r_h_ptr <= '0;
                  end else if (w_last_col) begin
                     r_w_ptr <= '0;
                     r_h_ptr <= r_h_ptr + HEIGHT_B'(1);
                  end else begin
                     r_w_ptr <= r_w_ptr + WIDTH_B'(1);
                  end
               end else if (w_drop) begin
                  r_drop_err   <= 1'b1;
                  r_frame_done <= 1'b1;
                  r_w_ptr      <= '0;
                  r_h_ptr      <= '0;
                  r_state      <= WRITE;
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign write_en   = r_write_en;
   assign write_w    = r_write_w;
   assign write_h    = r_write_h;
   assign write      = r_write;
   assign frame_done = r_frame_done;
   assign drop_err   = r_drop_err;

endmodule

// File: tb/tb_fmap_writer.sv
// Randomized self-checking bench for fmap_writer against a word-list / linear-index reference model.
// Build with or without FMAP_WRITER_ZERO_PAD_EN; the model follows the same macro.
module tb_fmap_writer;

   localparam int W = 57;
   localparam int H = 8;
`ifdef FMAP_WRITER_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, en, in_valid, in_last;
   logic [7:0]  in_data;
   logic        in_ready, write_en, frame_done, drop_err;
   logic [5:0]  write_w;
   logic [2:0]  write_h;
   logic [71:0] write;

   always #5 clk = ~clk;

   fmap_writer dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .write_en   (write_en),
      .write_w    (write_w),
      .write_h    (write_h),
      .write      (write),
      .frame_done (frame_done),
      .drop_err   (drop_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: bytes of the pending word, linear word index in the frame.
   logic [7:0]  m_bytes [$];
   int          m_idx = 0;
   bit          m_bubble = 1'b0;
   logic [71:0] m_write = '0;
   int          m_w = 0, m_h = 0;
   bit          m_we, m_fd, m_drop;

   task automatic cycle(input bit rst, input bit e, input bit v, input bit l,
                        input logic [7:0] d, output bit acc);
      bit          exp_ready;
      logic [71:0] word;
      reset = rst; en = e; in_valid = v; in_last = l; in_data = d;
      #1;
      exp_ready = e && !rst && !m_bubble;
      chk("in_ready", 72'(in_ready), 72'(exp_ready));
      acc = v && exp_ready;
      @(posedge clk);
      #1;
      m_we = 0; m_fd = 0; m_drop = 0;
      if (rst) begin
         m_bytes.delete();
         m_idx = 0; m_bubble = 0; m_write = '0; m_w = 0; m_h = 0;
      end else begin
         m_bubble = 0;
         if (acc) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 9 || (l && PAD)) begin
               word = '0;
               for (int i = 0; i < 9; i++)
                  word = {word[63:0], (i < m_bytes.size()) ? m_bytes[i] : 8'h00};
               m_write = word;
               m_w = m_idx % W;
               m_h = m_idx / W;
               m_we = 1;
               m_fd = l || (m_idx == W * H - 1);
               m_idx = m_fd ? 0 : m_idx + 1;
               m_bytes.delete();
               m_bubble = 1;
            end else if (l) begin
               m_bytes.delete();
               m_drop = 1; m_fd = 1; m_idx = 0; m_bubble = 1;
            end
         end
      end
      chk("write_en",   72'(write_en),   72'(m_we));
      chk("frame_done", 72'(frame_done), 72'(m_fd));
      chk("drop_err",   72'(drop_err),   72'(m_drop));
      chk("write",      write,           m_write);
      chk("write_w",    72'(write_w),    72'(m_w));
      chk("write_h",    72'(write_h),    72'(m_h));
   endtask

   task automatic send(input int n, input bit last_end, input bit rnd_ctl,
                       input bit use_fixed, input logic [7:0] fixed);
      int sent;
      bit a, e, v;
      sent = 0;
      for (int c = 0; c < n * 20 + 20 && sent < n; c++) begin
         e = 1; v = 1;
         if (rnd_ctl) begin
            e = ($urandom_range(9) != 0);
            v = ($urandom_range(4) != 0);
         end
         cycle(0, e, v, last_end && (sent == n - 1), use_fixed ? fixed : 8'($urandom), a);
         if (a) sent++;
      end
      chk("send_count", 72'(sent), 72'(n));
   endtask

   initial begin
      bit a;
      int nb;
      reset = 1; en = 0; in_valid = 0; in_last = 0; in_data = 0;

      cycle(1, 1, 0, 0, 8'h00, a);
      cycle(1, 1, 0, 0, 8'h00, a);

      // Bytes 0x01..0x12 with valid held high: two words at (0,0) and (1,0).
      nb = 0;
      for (int c = 0; c < 40 && nb < 18; c++) begin
         cycle(0, 1, 1, 0, 8'(nb + 1), a);
         if (a) begin
            nb++;
            if (nb == 9)  chk("tp_word0", write, 72'h010203040506070809);
            if (nb == 18) chk("tp_word1", write, 72'h0A0B0C0D0E0F101112);
            if (nb == 18) chk("tp_word1_w", 72'(write_w), 72'd1);
         end
      end
      chk("tp_bytes", 72'(nb), 72'd18);

      // Rest of a full frame without in_last, then one word wrapping back to (0,0).
      send(W * H * 9 - 18, 0, 1, 0, 8'h00);
      send(9, 0, 0, 0, 8'h00);
      chk("wrap_addr", 72'({write_w, write_h}), 72'd0);

      // Short final word: four 0xAA bytes, last on the fourth.
      send(4, 1, 0, 1, 8'hAA);
      if (PAD) chk("pad_word", write, 72'hAAAAAAAA0000000000);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 8'h00, a);

      // en held low mid-word, then resume; later reset mid-word.
      send(5, 0, 0, 0, 8'h00);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 8'h5A, a);
      send(4, 0, 0, 0, 8'h00);
      send(3, 0, 0, 0, 8'h00);
      cycle(1, 1, 1, 0, 8'h77, a);
      for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 8'h00, a);
      send(9, 0, 0, 0, 8'h00);

      // Fully random traffic including resets and in_last.
      for (int c = 0; c < 3000; c++) begin
         cycle($urandom_range(99) == 0, $urandom_range(9) != 0, $urandom_range(4) != 0,
               $urandom_range(24) == 0, 8'($urandom), a);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
